// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer: track/hold control, MSB-first trial codes,
// result strobe, and PGA gain updates that happen only at the start of a conversion.
module sar_adc_ctrl #(
  parameter int DATA_W        = 13,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              pga_high_gain_req,
  input  logic              comp_in,
  output logic              sample_hold,
  output logic [DATA_W-1:0] dac_code,
  output logic              pga_high_gain,
  output logic [DATA_W-1:0] meas_val,
  output logic              meas_val_valid,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SC_W  = $clog2(SAMPLE_CYCLES);
  localparam int ST_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DATA_W-1:0] LSB_ONE = DATA_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [SC_W-1:0]   r_samp_cnt;
  logic [ST_W-1:0]   r_settle_cnt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_dac;
  logic [DATA_W-1:0] r_meas;
  logic              r_valid;
  logic              r_sample_hold;
  logic              r_pga;

  logic [DATA_W-1:0] w_bit_mask;
  logic [DATA_W-1:0] w_next_mask;
  logic [DATA_W-1:0] w_resolved;

  // Trial bit under test, the next lower trial bit, and the code after the comparator decision.
  assign w_bit_mask  = LSB_ONE << r_bit_idx;
  assign w_next_mask = LSB_ONE << (r_bit_idx - IDX_W'(1));
  assign w_resolved  = comp_in ? r_dac : (r_dac & ~w_bit_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_samp_cnt    <= '0;
      r_settle_cnt  <= '0;
      r_bit_idx     <= '0;
      r_dac         <= '0;
      r_meas        <= '0;
      r_valid       <= 1'b0;
      r_sample_hold <= 1'b0;
      r_pga         <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start || cont_mode) begin
            r_state       <= S_SAMPLE;
            r_sample_hold <= 1'b1;
            r_dac         <= '0;
            r_samp_cnt    <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SAMPLE: begin
          // Gain is latched once, leaving the rest of the track window for the PGA to settle.
          if (r_samp_cnt == '0) begin
            r_pga <= pga_high_gain_req;
          end
          if (r_samp_cnt == SC_W'(SAMPLE_CYCLES - 1)) begin
            r_sample_hold <= 1'b0;
            r_bit_idx     <= IDX_W'(DATA_W - 1);
            r_dac         <= LSB_ONE << (DATA_W - 1);
            r_settle_cnt  <= '0;
            r_state       <= S_SETTLE;
          end else begin
            r_samp_cnt <= r_samp_cnt + SC_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == ST_W'(SETTLE_CYCLES - 1)) begin
            r_settle_cnt <= '0;
            if (r_bit_idx != '0) begin
              r_dac     <= w_resolved | w_next_mask;
              r_bit_idx <= r_bit_idx - IDX_W'(1);
            end else begin
              r_dac   <= w_resolved;
              r_meas  <= w_resolved;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + ST_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_hold    = r_sample_hold;
  assign dac_code       = r_dac;
  assign pga_high_gain  = r_pga;
  assign meas_val       = r_meas;
  assign meas_val_valid = r_valid;
  assign busy           = (r_state != S_IDLE);
  assign dbg_state      = r_state;

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation ADC sequencer that produces the measurement stream consumed by the digital gain-control logic. It drives the sample/hold switch and the trial DAC code of the analog front-end model. It resolves the comparator result MSB-first and delivers a DATA_W-bit result with a one-cycle valid strobe. It also applies the PGA gain request only at a conversion boundary, so gain never changes during a conversion.

Parameters:
DATA_W, 13, result width in bits and number of SAR steps
SAMPLE_CYCLES, 4, track (acquisition) cycles per conversion; must be >= 2
SETTLE_CYCLES, 2, cycles per SAR bit for DAC/comparator settling; must be >= 1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  conversion request; sampled only when idle
cont_mode  in  1  1 = back-to-back conversions without start
pga_high_gain_req  in  1  requested PGA gain from gain-control logic
comp_in  in  1  comparator: 1 = AFE input >= DAC level
sample_hold  out  1  1 = track, 0 = hold
dac_code  out  DATA_W  trial code to the SAR DAC
pga_high_gain  out  1  gain applied to the AFE
meas_val  out  DATA_W  last conversion result
meas_val_valid  out  1  one-cycle strobe; meas_val is new
busy  out  1  conversion in progress (any state but IDLE)

Behaviour:
- Reset, sampled on a rising clk edge while rst_n=0:
  - State goes to IDLE.
  - All outputs reset to 0: sample_hold, dac_code, pga_high_gain, meas_val, meas_val_valid, busy.
  - Reset mid-conversion aborts the conversion. No valid is emitted and meas_val becomes 0.
- States: IDLE, SAMPLE, SETTLE, DONE.
- IDLE:
  - On (start | cont_mode), go to SAMPLE at the next edge.
  - Otherwise stay in IDLE.
- SAMPLE:
  - Lasts exactly SAMPLE_CYCLES cycles. sample_hold=1 and dac_code=0.
  - pga_high_gain is loaded from pga_high_gain_req at the edge ending the first SAMPLE cycle. It holds that value until the next such edge.
  - The remaining SAMPLE_CYCLES-1 cycles settle the PGA at the new gain.
  - At the last SAMPLE edge: sample_hold goes to 0, bit index i = DATA_W-1, dac_code = 1<<i, and the state goes to SETTLE.
- SETTLE:
  - Each bit lasts SETTLE_CYCLES cycles. comp_in is sampled only at the final edge of the bit.
  - If comp_in=0, bit i of the code is cleared; if comp_in=1, it is kept.
  - If i > 0: i decrements and bit i-1 is set in dac_code (trial).
  - If i = 0: the final code goes to both meas_val and dac_code, meas_val_valid becomes 1, and the state goes to DONE.
- DONE:
  - Lasts one cycle. meas_val_valid=1 and sample_hold=0.
  - At the next edge meas_val_valid returns to 0.
  - Then: if (start | cont_mode), go to SAMPLE; else go to IDLE.
- Latency and period:
  - With start sampled at edge 0, meas_val_valid is high in the cycle after edge N = SAMPLE_CYCLES + DATA_W*SETTLE_CYCLES (30 with defaults).
  - The continuous-mode period is N+1 cycles (31).
- Gain handshake: a gain request that changes at the edge where meas_val_valid is seen is applied to the immediately following conversion.
- start while busy=1 (except in DONE) is ignored and not queued.
- meas_val holds its value between strobes. It changes only at the edge that raises meas_val_valid.
- cont_mode deasserted mid-conversion lets the current conversion finish, then the block returns to IDLE.
- Arithmetic: the code register is DATA_W bits unsigned. Trial bits are set by OR and cleared by AND-NOT. There is no carry and no wrap.
- busy = (state != IDLE).

Test Plan:
- Comparator model with comp_in = (vin_code >= dac_code), vin_code=0x1ABC, one start pulse -> meas_val=0x1ABC with valid high exactly in the cycle after edge 30. Valid lasts 1 cycle and busy falls the cycle after.
- Edge codes: vin_code=0 -> meas_val=0x0000. vin_code=8191 -> meas_val=0x1FFF. Check the dac_code sequence 0x1000, 0x1800, ... for the all-ones case.
- cont_mode=1 with vin stepping: valid strobes exactly 31 cycles apart. sample_hold=1 for 4 cycles per conversion.
- pga_high_gain_req toggled to 1 at the edge where valid is seen -> pga_high_gain=1 at the edge ending the first SAMPLE cycle of the next conversion. It stays constant throughout SETTLE.
- start pulsed again mid-SETTLE -> ignored: one valid only, then IDLE.
- rst_n=0 for 1 cycle during bit 6 of SETTLE -> all outputs 0 next cycle, no valid. A new start then yields a correct result after 30 edges.
